// File: rtl/data_trans_fifo_mod_p_if.sv
// ---------------------------------------------------------------------------
// data_trans_fifo_mod_p_if
// Groups the word-input handshake and the symbol-output stream of
// data_trans_fifo_mod_p.
//   start     : pulse, arms the SOF tag for the next accepted word
//   wr_valid  : input word valid
//   wr_data   : input word (DATA_W bits)
//   wr_last   : EOF tag for wr_data
//   wr_ready  : word can be accepted this cycle
//   dmod      : current output symbol (SYM_W bits)
//   mod_en    : dmod valid
//   sof / eof : first symbol of an SOF word / last symbol of an EOF word
// master = word source and symbol sink, slave = the FIFO/modulator.
// ---------------------------------------------------------------------------
interface data_trans_fifo_mod_p_if #(
    parameter int DATA_W = 8,
    parameter int SYM_W  = 4
);
    logic              start;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic [SYM_W-1:0]  dmod;
    logic              mod_en;
    logic              sof;
    logic              eof;

    modport master (
        output start, wr_valid, wr_data, wr_last,
        input  wr_ready, dmod, mod_en, sof, eof
    );

    modport slave (
        input  start, wr_valid, wr_data, wr_last,
        output wr_ready, dmod, mod_en, sof, eof
    );
endinterface

// File: rtl/data_trans_fifo_mod_p.sv
// ---------------------------------------------------------------------------
// data_trans_fifo_mod_p
// Buffers DATA_W-bit words (tagged SOF/EOF) in a DEPTH-entry first-word-
// fall-through FIFO and serialises each word MSB-first into SYM_W-bit
// symbols, each held HOLD clocks on dmod. Optional Gray mapping of symbols.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : word handshake in / symbol stream out (slave modport)
//   gray_en      : 1 = Gray-map symbols (sampled at each symbol boundary)
//   clr_flags    : clears overflow/underrun (a same-cycle set wins)
//   full         : level == DEPTH
//   almost_full  : level >= AF_LEVEL
//   level        : FIFO occupancy
//   overflow     : sticky, a write was attempted while full
//   underrun     : sticky, stream ran dry after a word without EOF tag
// ---------------------------------------------------------------------------
module data_trans_fifo_mod_p #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 64,
    parameter int SYM_W    = 4,
    parameter int HOLD     = 4,
    parameter int AF_LEVEL = 60
) (
    input  logic                      clk,
    input  logic                      reset,
    data_trans_fifo_mod_p_if.slave    bus,
    input  logic                      gray_en,
    input  logic                      clr_flags,
    output logic                      full,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      underrun
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int NSYM  = DATA_W / SYM_W;
    localparam int SC_W  = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int HC_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int ENT_W = DATA_W + 2;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic [SYM_W-1:0] map_sym(input logic [SYM_W-1:0] bin,
                                                 input logic g);
        return g ? (bin ^ (bin >> 1)) : bin;
    endfunction

    // FIFO storage and pointers
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              empty;
    logic              push;
    logic              pop;
    logic              armed;
    logic              sof_tag;
    logic [ENT_W-1:0]  head;
    logic              head_sof;
    logic              head_eof;
    logic [DATA_W-1:0] head_data;

    // Modulator state
    state_t            state;
    logic [DATA_W-1:0] sh_reg;
    logic [DATA_W-1:0] sh_next;
    logic [SC_W-1:0]   sym_cnt;
    logic [HC_W-1:0]   hold_cnt;
    logic              cur_eof;
    logic              hold_end;
    logic              last_sym;
    logic              word_end;
    logic              load;
    logic              step;
    logic [SYM_W-1:0]  dmod_q;
    logic              mod_en_q;
    logic              sof_q;
    logic              eof_q;

    assign empty       = (level == '0);
    assign full        = (level == LVL_W'(DEPTH));
    assign almost_full = (level >= LVL_W'(AF_LEVEL));
    assign push        = bus.wr_valid & ~full;
    assign sof_tag     = bus.start | armed;

    assign head      = mem[rd_ptr];
    assign head_sof  = head[ENT_W-1];
    assign head_eof  = head[ENT_W-2];
    assign head_data = head[DATA_W-1:0];

    assign sh_next  = sh_reg << SYM_W;
    assign hold_end = (hold_cnt == HC_W'(HOLD - 1));
    assign last_sym = (sym_cnt == SC_W'(NSYM - 1));
    assign word_end = (state == SHIFT) && hold_end && last_sym;
    // A new word is taken either from idle or on the final hold cycle of the
    // current word, which keeps back-to-back words gapless.
    assign load     = ~empty && ((state == IDLE) || word_end);
    assign step     = (state == SHIFT) && hold_end && ~last_sym;
    assign pop      = load;

    assign bus.wr_ready = ~full;
    assign bus.dmod     = dmod_q;
    assign bus.mod_en   = mod_en_q;
    assign bus.sof      = sof_q;
    assign bus.eof      = eof_q;

    // FIFO write port (data only, no reset)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sof_tag, bus.wr_last, bus.wr_data};
        end
    end

    // Shift register (data only, no reset)
    always_ff @(posedge clk) begin
        if (load) begin
            sh_reg <= head_data;
        end else if (step) begin
            sh_reg <= sh_next;
        end
    end

    // Control: FIFO pointers/level, SOF arm, FSM, registered outputs, flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            armed    <= 1'b0;
            state    <= IDLE;
            sym_cnt  <= '0;
            hold_cnt <= '0;
            cur_eof  <= 1'b0;
            dmod_q   <= '0;
            mod_en_q <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: ;
            endcase

            // Repeated start pulses only re-arm; acceptance consumes the arm.
            if (push) begin
                armed <= 1'b0;
            end else if (bus.start) begin
                armed <= 1'b1;
            end

            if (load) begin
                state    <= SHIFT;
                sym_cnt  <= '0;
                hold_cnt <= '0;
                cur_eof  <= head_eof;
                mod_en_q <= 1'b1;
                dmod_q   <= map_sym(head_data[DATA_W-1 -: SYM_W], gray_en);
                sof_q    <= head_sof;
                eof_q    <= head_eof && (NSYM == 1);
            end else if (word_end) begin
                state    <= IDLE;
                mod_en_q <= 1'b0;
                dmod_q   <= '0;
                sof_q    <= 1'b0;
                eof_q    <= 1'b0;
            end else if (step) begin
                sym_cnt  <= sym_cnt + SC_W'(1);
                hold_cnt <= '0;
                dmod_q   <= map_sym(sh_next[DATA_W-1 -: SYM_W], gray_en);
                sof_q    <= 1'b0;
                eof_q    <= cur_eof && (int'(sym_cnt) == NSYM - 2);
            end else if (state == SHIFT) begin
                hold_cnt <= hold_cnt + HC_W'(1);
            end

            // Sticky flags: a set in the same cycle overrides clr_flags.
            if (bus.wr_valid && full) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end

            if (word_end && !load && !cur_eof) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_trans_fifo_mod_p.sv
// ---------------------------------------------------------------------------
// tb_data_trans_fifo_mod_p
// Scoreboard bench for data_trans_fifo_mod_p (DEPTH=4, AF_LEVEL=3, HOLD=4,
// DATA_W=8, SYM_W=4). Every accepted word pushes its expected symbol
// stream (one entry per mod_en cycle); a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_data_trans_fifo_mod_p;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int SYM_W    = 4;
    localparam int HOLD     = 4;
    localparam int AF_LEVEL = 3;
    localparam int NSYM     = DATA_W / SYM_W;
    localparam int LVL_W    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             gray_en;
    logic             clr_flags;
    logic             full;
    logic             almost_full;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             underrun;

    data_trans_fifo_mod_p_if #(.DATA_W(DATA_W), .SYM_W(SYM_W)) bus_if ();

    data_trans_fifo_mod_p #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SYM_W(SYM_W),
        .HOLD(HOLD), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if),
        .gray_en(gray_en),
        .clr_flags(clr_flags),
        .full(full),
        .almost_full(almost_full),
        .level(level),
        .overflow(overflow),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic             sof;
        logic             eof;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mod_cnt;
    int   run_len;
    int   max_run;
    int   max_level;
    logic seen_full;
    logic seen_af;
    logic seen_busy;
    logic model_armed;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected symbol stream of one word: NSYM symbols, HOLD entries each.
    task automatic sb_push_word(input logic [DATA_W-1:0] d, input logic s,
                                input logic l);
        logic [SYM_W-1:0] b;
        exp_t             e;
        for (int k = 0; k < NSYM; k++) begin
            b     = d[DATA_W-1-k*SYM_W -: SYM_W];
            e.sym = gray_en ? (b ^ (b >> 1)) : b;
            e.sof = s && (k == 0);
            e.eof = l && (k == NSYM - 1);
            for (int h = 0; h < HOLD; h++) begin
                sb.push_back(e);
            end
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.mod_en) begin
                mod_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb.size() == 0) begin
                    check_val("spurious_mod_en", 32'(bus_if.mod_en), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("sym_sof_eof",
                              32'({bus_if.dmod, bus_if.sof, bus_if.eof}), 32'(e));
                end
            end else begin
                run_len = 0;
            end
            if (full)            seen_full = 1'b1;
            if (almost_full)     seen_af   = 1'b1;
            if (!bus_if.wr_ready) seen_busy = 1'b1;
            if (int'(level) > max_level) max_level = int'(level);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        mod_cnt   = 0;
        run_len   = 0;
        max_run   = 0;
        max_level = 0;
        seen_full = 1'b0;
        seen_af   = 1'b0;
        seen_busy = 1'b0;
    endtask

    // Drive one write for one clock; exp_acc says whether the word must be
    // taken (the bench knows the FIFO fill from the scenario).
    task automatic wr_word(input logic [DATA_W-1:0] d, input logic last,
                           input logic st, input logic exp_acc);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = d;
        bus_if.wr_last  = last;
        bus_if.start    = st;
        if (exp_acc) begin
            sb_push_word(d, st | model_armed, last);
            model_armed = 1'b0;
        end else if (st) begin
            model_armed = 1'b1;
        end
        tick();
        bus_if.wr_valid = 1'b0;
        bus_if.wr_last  = 1'b0;
        bus_if.start    = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0 || bus_if.mod_en) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_val("drain_pending", 32'(sb.size()), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        gray_en         = 1'b0;
        clr_flags       = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.wr_valid = 1'b0;
        bus_if.wr_data  = '0;
        bus_if.wr_last  = 1'b0;
        model_armed     = 1'b0;
        clear_stats();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_mod_en", 32'(bus_if.mod_en), 32'd0);
        check_val("rst_dmod", 32'(bus_if.dmod), 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_wr_ready", 32'(bus_if.wr_ready), 32'd1);
        check_val("rst_flags", 32'({full, almost_full, overflow, underrun}), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Reset while shifting with words queued
        for (int i = 1; i <= 5; i++) begin
            wr_word(DATA_W'(8'h11 * i), 1'b1, 1'b0, 1'b1);
        end
        @(negedge clk);
        check_val("queued_level", 32'(level), 32'd4);
        check_val("queued_mod_en", 32'(bus_if.mod_en), 32'd1);
        #3;
        reset = 1'b1;
        sb.delete();
        model_armed = 1'b0;
        #1;
        check_val("arst_outs",
                  32'({bus_if.mod_en, bus_if.dmod, bus_if.sof, bus_if.eof}), 32'd0);
        check_val("arst_level", 32'(level), 32'd0);
        check_val("arst_wr_ready", 32'(bus_if.wr_ready), 32'd1);
        check_val("arst_full", 32'(full), 32'd0);
        tick();
        reset = 1'b0;
        clear_stats();
        repeat (20) tick();
        check_val("post_rst_mod_cnt", 32'(mod_cnt), 32'd0);
        check_val("post_rst_level", 32'(level), 32'd0);

        // Single SOF+EOF word, latency and symbol timing
        clear_stats();
        wr_word(8'hA5, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check_val("lat_first_cycle", 32'({bus_if.mod_en, level}), 32'({1'b0, LVL_W'(1)}));
        @(negedge clk);
        check_val("lat_second_cycle", 32'(bus_if.mod_en), 32'd1);
        drain(100);
        check_val("a5_mod_cnt", 32'(mod_cnt), 32'd8);
        check_val("a5_max_run", 32'(max_run), 32'd8);
        check_val("a5_underrun", 32'(underrun), 32'd0);

        // Gray-mapped word
        clear_stats();
        gray_en = 1'b1;
        wr_word(8'hB3, 1'b1, 1'b0, 1'b1);
        drain(100);
        gray_en = 1'b0;
        check_val("gray_mod_cnt", 32'(mod_cnt), 32'd8);

        // Three back-to-back words, frame tagged start/end
        clear_stats();
        wr_word(8'h12, 1'b0, 1'b1, 1'b1);
        wr_word(8'h34, 1'b0, 1'b0, 1'b1);
        wr_word(8'h56, 1'b1, 1'b0, 1'b1);
        drain(200);
        check_val("b2b_mod_cnt", 32'(mod_cnt), 32'd24);
        check_val("b2b_max_run", 32'(max_run), 32'd24);
        check_val("b2b_underrun", 32'(underrun), 32'd0);

        // Fill past DEPTH: first 5 taken (1 loaded + 4 buffered), rest dropped
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            wr_word(DATA_W'(8'h20 + i), 1'b1, (i == 0), (i < 5));
        end
        @(negedge clk);
        check_val("ovf_seen_full", 32'(seen_full), 32'd1);
        check_val("ovf_seen_af", 32'(seen_af), 32'd1);
        check_val("ovf_seen_busy", 32'(seen_busy), 32'd1);
        check_val("ovf_max_level", 32'(max_level), 32'd4);
        check_val("ovf_flag", 32'(overflow), 32'd1);
        tick();
        pulse_clr();
        @(negedge clk);
        check_val("ovf_cleared", 32'(overflow), 32'd0);
        drain(200);
        check_val("ovf_mod_cnt", 32'(mod_cnt), 32'd40);
        check_val("ovf_underrun", 32'(underrun), 32'd0);

        // Untagged word ends the stream -> underrun
        clear_stats();
        wr_word(8'h3C, 1'b0, 1'b0, 1'b1);
        drain(100);
        check_val("undr_set", 32'(underrun), 32'd1);
        pulse_clr();
        @(negedge clk);
        check_val("undr_cleared", 32'(underrun), 32'd0);

        // clr_flags on the very edge a new underrun is raised: set wins
        wr_word(8'h69, 1'b0, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        @(negedge clk);
        check_val("undr_set_wins", 32'(underrun), 32'd1);
        check_val("undr_idle", 32'(bus_if.mod_en), 32'd0);
        drain(50);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
